ifu_axi_fetch: RTL and testbench

- Parametrised instruction fetch unit that replaces the always-valid, combinational-address fetch path.
- Issues one AXI-lite read at a time with full AR/R handshaking and stable address.
- Buffers fetched {pc, inst} pairs in a small FIFO ahead of IDU; handles jump/interrupt redirects with flush and in-flight beat discard.

---
 rtl/ifu_pkg.sv | 14 +
 rtl/ifu_fifo.sv | 66 ++++++
 rtl/ifu_axi_fetch.sv | 144 ++++++++++++++
 tb/tb_ifu_axi_fetch.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared FSM type, defaults and lane helper for the fetch unit
package ifu_pkg;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} fetch_state_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam int          INST_W_DEFAULT   = 32;

  // Number of PC bits that pick an instruction lane within one read beat.
  function automatic int lane_idx_w(input int data_w, input int inst_w);
    return $clog2(data_w / inst_w);
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - synchronous FIFO with flush taking priority over push/pop
module ifu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifu_axi_fetch.sv
// rtl/ifu_axi_fetch.sv - AXI-lite instruction fetch with redirect flush and IDU buffer
// Optional IFU_ACCESS_FAULT_EN adds rresp/inst_fault and stalls fetch after a faulting beat.
module ifu_axi_fetch import ifu_pkg::*; #(
  parameter int              PC_W       = 64,
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 64,
  parameter int              INST_W     = INST_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(RESET_PC_DEFAULT),
  parameter int              FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              intr_valid,
  input  logic [PC_W-1:0]   intr_pc,
  input  logic              jump_valid,
  input  logic [PC_W-1:0]   jump_pc,
  output logic              arvalid,
  output logic [ADDR_W-1:0] araddr,
  input  logic              arready,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  output logic              rready,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              ifu_valid,
  input  logic              idu_ready
`ifdef IFU_ACCESS_FAULT_EN
  ,
  input  logic [1:0]        rresp,
  output logic              inst_fault
`endif
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int LIDX_W = lane_idx_w(DATA_W, INST_W);
`ifdef IFU_ACCESS_FAULT_EN
  localparam int ENTRY_W = 1 + PC_W + INST_W;
`else
  localparam int ENTRY_W = PC_W + INST_W;
`endif

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              redir_pend_q, redir_pend_d;
  logic              fault_stall_q, fault_stall_d;

  logic              redirect, push, pop, full, empty, beat_fault;
  logic [PC_W-1:0]   target, lane_sel;
  logic [INST_W-1:0] lane_inst, head_inst;
  logic [PC_W-1:0]   head_pc;
  logic [CNT_W-1:0]  count;
  logic [ENTRY_W-1:0] push_data, head_data;

  assign redirect  = intr_valid || jump_valid;
  assign target    = intr_valid ? intr_pc : jump_pc;
  assign lane_sel  = (fetch_pc_q >> 2) & PC_W'((1 << LIDX_W) - 1);
  assign lane_inst = INST_W'(rdata >> (lane_sel * PC_W'(INST_W)));
  // A beat is only kept if no redirect arrives in the same cycle.
  assign push      = (state_q == S_WAIT) && rvalid && !redirect && !full;
  assign pop       = idu_ready && !empty;

`ifdef IFU_ACCESS_FAULT_EN
  logic head_fault;
  assign beat_fault = (rresp != 2'b00);
  assign push_data  = {beat_fault, fetch_pc_q, lane_inst};
  assign {head_fault, head_pc, head_inst} = head_data;
  assign inst_fault = !empty && head_fault;
`else
  assign beat_fault = 1'b0;
  assign push_data  = {fetch_pc_q, lane_inst};
  assign {head_pc, head_inst} = head_data;
`endif

  ifu_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      araddr_q      <= '0;
      redir_pend_q  <= 1'b0;
      fault_stall_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      araddr_q      <= araddr_d;
      redir_pend_q  <= redir_pend_d;
      fault_stall_q <= fault_stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!redirect && !fault_stall_q && (count < CNT_W'(FIFO_DEPTH))) state_d = S_REQ;
      S_REQ:  if (arready) state_d = (redirect || redir_pend_q) ? S_DROP : S_WAIT;
      S_WAIT: if (rvalid) state_d = S_IDLE; else if (redirect) state_d = S_DROP;
      S_DROP: if (rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    araddr_d      = araddr_q;
    redir_pend_d  = redir_pend_q;
    fault_stall_d = fault_stall_q;
    // Address is captured once so it stays put even if fetch_pc is redirected mid-REQ.
    if (state_q == S_IDLE && state_d == S_REQ)
      araddr_d = ADDR_W'(fetch_pc_q) & ~ADDR_W'(DATA_W / 8 - 1);
    if (state_q == S_REQ)
      redir_pend_d = arready ? 1'b0 : (redir_pend_q || redirect);
    if (push) begin
      fetch_pc_d = fetch_pc_q + PC_W'(4);
      if (beat_fault) fault_stall_d = 1'b1;
    end
    if (redirect) begin
      fetch_pc_d    = target;
      fault_stall_d = 1'b0;
    end
  end

  always_comb begin
    arvalid   = (state_q == S_REQ);
    rready    = (state_q == S_WAIT) || (state_q == S_DROP);
    araddr    = araddr_q;
    ifu_valid = !empty;
    inst_o    = empty ? '0 : head_inst;
    pc_o      = empty ? '0 : head_pc;
  end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// tb/tb_ifu_axi_fetch.sv - scoreboard bench: byte-memory slave model, directed and random redirects
module tb_ifu_axi_fetch;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        intr_valid = 1'b0, jump_valid = 1'b0, idu_ready = 1'b0;
  logic [63:0] intr_pc = '0, jump_pc = '0;
  logic        arvalid, arready, rvalid, rready, ifu_valid;
  logic [31:0] araddr, inst_o;
  logic [63:0] rdata, pc_o;
  logic [1:0]  rresp;
`ifdef IFU_ACCESS_FAULT_EN
  logic        inst_fault;
`endif

  always #5 clk = ~clk;

  ifu_axi_fetch dut (
    .clk(clk), .rst(rst),
    .intr_valid(intr_valid), .intr_pc(intr_pc),
    .jump_valid(jump_valid), .jump_pc(jump_pc),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready),
    .inst_o(inst_o), .pc_o(pc_o), .ifu_valid(ifu_valid), .idu_ready(idu_ready)
`ifdef IFU_ACCESS_FAULT_EN
    , .rresp(rresp), .inst_fault(inst_fault)
`endif
  );

  int          pass_cnt = 0, total_cnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] ar_log[$];
  logic [63:0] pop_log[$];
  int          r_lat = 0;
  bit          rnd = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_n = 0;
  bit          stall_done = 0;
  int          stall_seen = 0;
  logic [31:0] fault_addr = 32'hFFFF_FFFF;

  // Instruction stored at each word of the slave's byte-addressed memory.
  function automatic logic [31:0] inst_at(input logic [63:0] pc);
    logic [31:0] a;
    a = pc[31:0];
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
  endfunction

  function automatic logic [63:0] ar_at(input int i);
    return (i < ar_log.size()) ? 64'(ar_log[i]) : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [63:0] pop_at(input int i);
    return (i < pop_log.size()) ? pop_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic exp_reset(input logic [63:0] pc);
    exp_q.delete();
    exp_q.push_back(pc);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    jump_valid = 1'b0;
    intr_valid = 1'b0;
    idu_ready = 1'b0;
    exp_reset(RPC);
    ar_log.delete();
    pop_log.delete();
    stall_seen = 0;
    stall_done = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_ar(input int n, input int budget);
    int i;
    i = 0;
    while (ar_log.size() < n && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk("ar_count_reached", 64'(ar_log.size() >= n), 64'd1);
  endtask

  // AXI-lite slave: memory beat = two consecutive words starting at the aligned address.
  initial begin : slave
    bit ar_fire, r_fire, pending;
    logic [31:0] ar_addr_s, pend_addr;
    int delay, wait_cnt;
    pending = 0; delay = 0; wait_cnt = 0; pend_addr = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clk);
      ar_fire = arvalid && arready;
      r_fire = rvalid && rready;
      ar_addr_s = araddr;
      @(posedge clk); #1;
      if (!rst) begin
        pending = 0; wait_cnt = 0; arready = 1'b0; rvalid = 1'b0;
      end else begin
        if (r_fire) begin
          rvalid = 1'b0; pending = 0; rdata = {$urandom, $urandom}; rresp = 2'b00;
        end
        if (ar_fire) begin
          pending = 1; pend_addr = ar_addr_s; wait_cnt = 0; arready = 1'b0;
          delay = rnd ? int'($urandom_range(0, 4)) : r_lat;
          if (ar_addr_s == stall_addr) stall_done = 1;
        end
        if (pending && !rvalid) begin
          if (delay == 0) begin
            rvalid = 1'b1;
            rdata = {inst_at(64'(pend_addr) + 64'd4), inst_at(64'(pend_addr))};
            rresp = (pend_addr == fault_addr) ? 2'b10 : 2'b00;
          end else delay--;
        end else if (!pending) begin
          if (!arvalid) arready = 1'b0;
          else if (rnd) arready = ($urandom_range(0, 2) == 0);
          else if (araddr == stall_addr && !stall_done && wait_cnt < stall_n) begin
            arready = 1'b0; wait_cnt++;
          end else arready = 1'b1;
        end
      end
    end
  end

  // Monitor: AR log/stability plus output scoreboard.
  bit          prev_ar_wait = 0, prev_hold = 0;
  logic [31:0] prev_araddr, prev_inst;
  logic [63:0] prev_pc;
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      prev_ar_wait = 0;
      prev_hold = 0;
    end else begin
      if (prev_ar_wait) begin
        chk("ar_hold_valid", 64'(arvalid), 64'd1);
        chk("ar_hold_addr", 64'(araddr), 64'(prev_araddr));
      end
      if (prev_hold) begin
        chk("out_hold_valid", 64'(ifu_valid), 64'd1);
        chk("out_hold_pc", pc_o, prev_pc);
        chk("out_hold_inst", 64'(inst_o), 64'(prev_inst));
      end
      if (arvalid && !arready && araddr == stall_addr) stall_seen++;
      if (arvalid && arready) begin
        ar_log.push_back(araddr);
        chk("ar_align", 64'(araddr[2:0]), 64'd0);
      end
      if (!(intr_valid || jump_valid) && ifu_valid && idu_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        chk("pop_pc", pc_o, e);
        chk("pop_inst", 64'(inst_o), 64'(inst_at(e)));
`ifdef IFU_ACCESS_FAULT_EN
        chk("pop_fault", 64'(inst_fault), 64'((e[31:0] & ~32'h7) == fault_addr));
`endif
        pop_log.push_back(pc_o);
        exp_q.push_back(e + 64'd4);
      end
      prev_ar_wait = arvalid && !arready;
      prev_araddr = araddr;
      prev_hold = ifu_valid && !idu_ready && !(intr_valid || jump_valid);
      prev_pc = pc_o;
      prev_inst = inst_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_pop, n_ar;
    repeat (3) @(posedge clk); #1;
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_ifu_valid", 64'(ifu_valid), 64'd0);
    chk("rst_inst_o", 64'(inst_o), 64'd0);
    chk("rst_pc_o", pc_o, 64'd0);

    // Straight-line fetch with zero-latency slave.
    do_reset();
    idu_ready = 1'b1;
    rst = 1'b1;
    wait_ar(3, 60);
    repeat (20) @(posedge clk); #1;
    chk("line_ar0", ar_at(0), 64'h8000_0000);
    chk("line_ar1", ar_at(1), 64'h8000_0000);
    chk("line_ar2", ar_at(2), 64'h8000_0008);
    chk("line_pc0", pop_at(0), 64'h8000_0000);
    chk("line_pc1", pop_at(1), 64'h8000_0004);
    chk("line_pc2", pop_at(2), 64'h8000_0008);

    // Buffer fills to exactly FIFO_DEPTH entries, then one pop admits one more fetch.
    do_reset();
    rst = 1'b1;
    repeat (40) @(posedge clk); #1;
    chk("full_ar_count", 64'(ar_log.size()), 64'd4);
    chk("full_arvalid", 64'(arvalid), 64'd0);
    chk("full_ifu_valid", 64'(ifu_valid), 64'd1);
    idu_ready = 1'b1;
    @(posedge clk); #1;
    idu_ready = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("full_pop_count", 64'(pop_log.size()), 64'd1);
    chk("full_ar_after_pop", 64'(ar_log.size()), 64'd5);
    chk("full_arvalid_again", 64'(arvalid), 64'd0);

    // arready withheld for 3 cycles on the fifth request.
    do_reset();
    stall_addr = 32'h8000_0010;
    stall_n = 3;
    idu_ready = 1'b1;
    rst = 1'b1;
    wait_ar(6, 120);
    repeat (20) @(posedge clk); #1;
    chk("stall_ar4", ar_at(4), 64'h8000_0010);
    chk("stall_cycles", 64'(stall_seen), 64'd3);
    chk("stall_pc4", pop_at(4), 64'h8000_0010);
    stall_addr = 32'hFFFF_FFFF;

    // Jump while a beat is outstanding.
    r_lat = 6;
    do_reset();
    idu_ready = 1'b1;
    rst = 1'b1;
    wait_ar(2, 60);
    n_pop = pop_log.size();
    jump_pc = 64'h8000_1000;
    jump_valid = 1'b1;
    exp_reset(64'h8000_1000);
    @(posedge clk); #1;
    jump_valid = 1'b0;
    wait_ar(3, 60);
    repeat (30) @(posedge clk); #1;
    chk("jump_ar", ar_at(2), 64'h8000_1000);
    chk("jump_pc_o", pop_at(n_pop), 64'h8000_1000);

    // Interrupt beats a simultaneous jump; issued from IDLE with a full buffer.
    r_lat = 0;
    do_reset();
    rst = 1'b1;
    repeat (40) @(posedge clk); #1;
    n_ar = ar_log.size();
    n_pop = pop_log.size();
    intr_pc = 64'h8000_0100;
    jump_pc = 64'h8000_2000;
    intr_valid = 1'b1;
    jump_valid = 1'b1;
    idu_ready = 1'b1;
    exp_reset(64'h8000_0100);
    @(posedge clk); #1;
    intr_valid = 1'b0;
    jump_valid = 1'b0;
    wait_ar(n_ar + 1, 60);
    repeat (20) @(posedge clk); #1;
    chk("intr_ar", ar_at(n_ar), 64'h8000_0100);
    chk("intr_pc_o", pop_at(n_pop), 64'h8000_0100);

    // Reset asserted while waiting for read data.
    r_lat = 6;
    do_reset();
    idu_ready = 1'b1;
    rst = 1'b1;
    wait_ar(1, 60);
    rst = 1'b0;
    #1;
    chk("midrst_arvalid", 64'(arvalid), 64'd0);
    chk("midrst_rready", 64'(rready), 64'd0);
    chk("midrst_ifu_valid", 64'(ifu_valid), 64'd0);
    chk("midrst_pc_o", pc_o, 64'd0);
    chk("midrst_inst_o", 64'(inst_o), 64'd0);
    do_reset();
    idu_ready = 1'b1;
    rst = 1'b1;
    wait_ar(1, 60);
    chk("midrst_first_ar", ar_at(0), 64'h8000_0000);
    r_lat = 0;

`ifdef IFU_ACCESS_FAULT_EN
    // Error response on the third fetch stalls the fetcher until a redirect.
    do_reset();
    fault_addr = 32'h8000_0008;
    idu_ready = 1'b1;
    rst = 1'b1;
    repeat (40) @(posedge clk); #1;
    chk("fault_ar_count", 64'(ar_log.size()), 64'd3);
    chk("fault_pc", pop_at(2), 64'h8000_0008);
    jump_pc = 64'h8000_0100;
    jump_valid = 1'b1;
    exp_reset(64'h8000_0100);
    @(posedge clk); #1;
    jump_valid = 1'b0;
    wait_ar(4, 60);
    chk("fault_resume_ar", ar_at(3), 64'h8000_0100);
    repeat (10) @(posedge clk); #1;
    fault_addr = 32'hFFFF_FFFF;
`endif

    // Random slave timing, IDU backpressure and redirects.
    rnd = 1;
    do_reset();
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int k;
      idu_ready = ($urandom_range(0, 3) != 0);
      jump_valid = 1'b0;
      intr_valid = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        k = $urandom_range(0, 2);
        jump_pc = RPC + 64'($urandom_range(0, 4095)) * 64'd4;
        intr_pc = RPC + 64'($urandom_range(0, 4095)) * 64'd4;
        jump_valid = (k != 1);
        intr_valid = (k != 0);
        exp_reset(intr_valid ? intr_pc : jump_pc);
      end
      @(posedge clk); #1;
    end
    jump_valid = 1'b0;
    intr_valid = 1'b0;
    idu_ready = 1'b1;
    repeat (40) @(posedge clk); #1;
    chk("random_progress", 64'(pop_log.size() > 200), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
